// File: rtl/offset_load_ctrl.sv
// Bulk loader for the vertex-offset table: issues credit-limited HBM reads,
// counts returned beats, then waits for every core to finish its URAM fill.
module offset_load_ctrl #(
  parameter int                    HBM_AWIDTH      = 33,
  parameter logic [HBM_AWIDTH-1:0] BASE_ADDR       = {HBM_AWIDTH{1'b0}},
  parameter int                    BEAT_COUNT      = 4096,
  parameter int                    MAX_OUTSTANDING = 32,
  parameter int                    CORE_NUM        = 16,
  parameter int                    CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hbm_full,
  input  logic                  hbm_data_valid,
  input  logic [CORE_NUM-1:0]   core_done,
  output logic [HBM_AWIDTH-1:0] hbm_addr,
  output logic                  hbm_addr_valid,
  output logic                  busy,
  output logic                  load_done,
  output logic                  err_unexpected
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_WIDTH-1:0] BEAT_CNT_C = CNT_WIDTH'(BEAT_COUNT);
  localparam logic [OUT_W-1:0]     MAX_OUT_C  = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_DRAIN      = 3'd2,
    S_WAIT_CORES = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t                  state_r;
  logic [CNT_WIDTH-1:0]    issue_cnt_r;
  logic [CNT_WIDTH-1:0]    recv_cnt_r;
  logic [OUT_W-1:0]        outstanding_r;
  logic [HBM_AWIDTH-1:0]   hbm_addr_r;
  logic                    hbm_addr_valid_r;
  logic                    busy_r;
  logic                    load_done_r;
  logic                    err_r;

  logic                    issue_s;
  logic                    take_s;
  logic                    beat_err_s;
  logic                    last_issue_s;
  logic                    cores_ready_s;
  logic [OUT_W-1:0]        out_nxt_s;
  logic [HBM_AWIDTH-1:0]   issue_addr_s;

  // Issue/accept decisions and the next outstanding-credit count.
  always_comb begin
    issue_s       = 1'b0;
    take_s        = 1'b0;
    out_nxt_s     = outstanding_r;
    if ((state_r == S_ISSUE) && !hbm_full && (outstanding_r < MAX_OUT_C)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    // A beat is only legitimate while reads are actually in flight.
    if (hbm_data_valid && ((state_r == S_ISSUE) || (state_r == S_DRAIN)) &&
        (outstanding_r != {OUT_W{1'b0}})) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
    case ({issue_s, take_s})
      2'b10:   out_nxt_s = outstanding_r + OUT_W'(1);
      2'b01:   out_nxt_s = outstanding_r - OUT_W'(1);
      default: out_nxt_s = outstanding_r;
    endcase
  end

  assign beat_err_s    = hbm_data_valid & ~take_s;
  assign last_issue_s  = (issue_cnt_r == (BEAT_CNT_C - CNT_WIDTH'(1)));
  assign cores_ready_s = &core_done;
  assign issue_addr_s  = BASE_ADDR + HBM_AWIDTH'(issue_cnt_r);

  // Load sequencer with registered request and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= S_IDLE;
      issue_cnt_r      <= {CNT_WIDTH{1'b0}};
      recv_cnt_r       <= {CNT_WIDTH{1'b0}};
      outstanding_r    <= {OUT_W{1'b0}};
      hbm_addr_r       <= {HBM_AWIDTH{1'b0}};
      hbm_addr_valid_r <= 1'b0;
      busy_r           <= 1'b0;
      load_done_r      <= 1'b0;
      err_r            <= 1'b0;
    end else begin
      hbm_addr_valid_r <= issue_s;
      if (issue_s) begin
        hbm_addr_r <= issue_addr_s;
      end
      outstanding_r <= out_nxt_s;
      if (take_s) begin
        recv_cnt_r <= recv_cnt_r + CNT_WIDTH'(1);
      end
      if (beat_err_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r       <= S_ISSUE;
            busy_r        <= 1'b1;
            load_done_r   <= 1'b0;
            issue_cnt_r   <= {CNT_WIDTH{1'b0}};
            recv_cnt_r    <= {CNT_WIDTH{1'b0}};
            outstanding_r <= {OUT_W{1'b0}};
          end
        end
        S_ISSUE: begin
          if (issue_s) begin
            issue_cnt_r <= issue_cnt_r + CNT_WIDTH'(1);
            if (last_issue_s) begin
              state_r <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (recv_cnt_r == BEAT_CNT_C) begin
            state_r <= S_WAIT_CORES;
          end
        end
        S_WAIT_CORES: begin
          if (cores_ready_s) begin
            state_r     <= S_DONE;
            busy_r      <= 1'b0;
            load_done_r <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign hbm_addr       = hbm_addr_r;
  assign hbm_addr_valid = hbm_addr_valid_r;
  assign busy           = busy_r;
  assign load_done      = load_done_r;
  assign err_unexpected = err_r;

endmodule

// File: tb/tb_offset_load_ctrl.sv
// Directed bench for offset_load_ctrl: 8-beat loads from 0x100 with a
// 4-deep credit limit, backpressure, core-fill wait, restart and error cases.
module tb_offset_load_ctrl;

  localparam int AW = 33;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          hbm_full;
  logic          hbm_data_valid;
  logic [15:0]   core_done;
  logic [AW-1:0] hbm_addr;
  logic          hbm_addr_valid;
  logic          busy;
  logic          load_done;
  logic          err_unexpected;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  int            nvalid   = 0;
  logic [63:0]   vbits;
  logic [AW-1:0] addrs[$];
  logic [1:0]    ret_pipe;
  bit            auto_ret;

  offset_load_ctrl #(
    .HBM_AWIDTH(AW), .BASE_ADDR(33'h100), .BEAT_COUNT(8),
    .MAX_OUTSTANDING(4), .CORE_NUM(16), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hbm_full(hbm_full),
    .hbm_data_valid(hbm_data_valid), .core_done(core_done),
    .hbm_addr(hbm_addr), .hbm_addr_valid(hbm_addr_valid), .busy(busy),
    .load_done(load_done), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: sample just after the edge, log requests, model the 2-cycle beat return.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (hbm_addr_valid) begin
      addrs.push_back(hbm_addr);
      nvalid++;
      if (cyc < 64) vbits[cyc] = 1'b1;
    end
    if (auto_ret) begin
      hbm_data_valid = ret_pipe[1];
      ret_pipe = {ret_pipe[0], hbm_addr_valid};
    end
  endtask

  task automatic do_start();
    ret_pipe = 2'b00;
    addrs.delete();
    nvalid = 0;
    vbits = 64'd0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    hbm_data_valid = 1'b0;
    ret_pipe = 2'b00;
    cycle();
    rst = 1'b0;
    chk({tag, "_addr"},  {31'd0, hbm_addr}, 64'd0);
    chk({tag, "_valid"}, {63'd0, hbm_addr_valid}, 64'd0);
    chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
    chk({tag, "_done"},  {63'd0, load_done}, 64'd0);
    chk({tag, "_err"},   {63'd0, err_unexpected}, 64'd0);
  endtask

  // Full load with optional hbm_full window (decision cycles ff..ft).
  task automatic run_load(input string tag, input int ff, input int ft);
    do_start();
    for (int i = 0; i < 80 && !load_done; i++) begin
      cycle();
      if (cyc == ff - 1) hbm_full = 1'b1;
      if (cyc == ft) hbm_full = 1'b0;
    end
    chk({tag, "_nvalid"}, 64'(nvalid), 64'd8);
    for (int i = 0; i < addrs.size() && i < 8; i++)
      chk({tag, "_addr"}, {31'd0, addrs[i]}, 64'h100 + 64'(i));
    chk({tag, "_load_done"}, {63'd0, load_done}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hbm_full = 1'b0; hbm_data_valid = 1'b0;
    core_done = 16'hFFFF; auto_ret = 1'b1; ret_pipe = 2'b00; vbits = 64'd0;
    cycle(); cycle();
    do_reset("reset");

    // Basic load: eight back-to-back requests starting one cycle after ISSUE.
    run_load("basic", -10, -10);
    chk("basic_pattern", {55'd0, vbits[9:1]}, 64'h0FF);
    chk("basic_err", {63'd0, err_unexpected}, 64'd0);

    // Restart from DONE with one core lagging.
    core_done = 16'hFFFE;
    do_start();
    chk("restart_done_clr", {63'd0, load_done}, 64'd0);
    chk("restart_busy", {63'd0, busy}, 64'd1);
    repeat (20) cycle();
    chk("wait_nvalid", 64'(nvalid), 64'd8);
    begin
      bit early = 1'b0;
      for (int i = 0; i < 10; i++) begin
        cycle();
        if (load_done || !busy) early = 1'b1;
      end
      chk("wait_cores_hold", {63'd0, early}, 64'd0);
    end
    core_done = 16'hFFFF;
    cycle();
    chk("wait_cores_done", {63'd0, load_done}, 64'd1);
    chk("wait_cores_busy", {63'd0, busy}, 64'd0);

    // Backpressure on decision cycles 3..6.
    run_load("full", 3, 6);
    chk("full_pattern", {52'd0, vbits[12:1]}, 64'hFC3);

    // Credit limit: no returns, four requests then stall; one beat frees one slot.
    auto_ret = 1'b0;
    hbm_data_valid = 1'b0;
    do_start();
    repeat (20) cycle();
    chk("credit_nvalid4", 64'(nvalid), 64'd4);
    hbm_data_valid = 1'b1;
    cycle();
    hbm_data_valid = 1'b0;
    repeat (10) cycle();
    chk("credit_nvalid5", 64'(nvalid), 64'd5);
    chk("credit_addr5", {31'd0, addrs[addrs.size()-1]}, 64'h104);
    chk("credit_err", {63'd0, err_unexpected}, 64'd0);
    do_reset("credit_rst");

    // Reset mid-ISSUE after five issues, then reload from BASE_ADDR.
    auto_ret = 1'b1;
    do_start();
    for (int i = 0; i < 20 && nvalid < 5; i++) cycle();
    chk("mid_nvalid", 64'(nvalid), 64'd5);
    do_reset("mid_rst");
    run_load("reload", -10, -10);

    // Stray beat in IDLE is sticky across a full load.
    do_reset("pre_err");
    hbm_data_valid = 1'b1;
    cycle();
    hbm_data_valid = 1'b0;
    cycle();
    chk("err_idle", {63'd0, err_unexpected}, 64'd1);
    run_load("err_load", -10, -10);
    chk("err_sticky", {63'd0, err_unexpected}, 64'd1);
    do_reset("err_clr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
